chunk_stream_writer: RTL and testbench
======================================

CHUNK_STREAM_WRITER -- requirements
Module: chunk_stream_writer

Interface
REQ-001 Parameter LAST_PANEL, default 3, meaning: highest panel_addr written before a frame completes.
REQ-002 Parameter MSB_FIRST, default 0, meaning: 0 places the first byte of a chunk in bits 7:0; 1 places it in bits 31:24.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  8  host byte stream.
REQ-006 in_valid  input  1  in_data valid; a byte is accepted when in_valid and in_ready are both high.
REQ-007 in_sof  input  1  marks the accepted byte as the first byte of a frame.
REQ-008 in_ready  output  1  writer can accept a byte.
REQ-009 chunk_data  output  32  assembled chunk word.
REQ-010 chunk_addr  output  4  chunk index within row.
REQ-011 row_addr  output  4  row index.
REQ-012 panel_addr  output  2  panel index.
REQ-013 chunk_write_enable  output  1  one-cycle write strobe to the LED controller.
REQ-014 frame_done  output  1  one-cycle pulse; full frame written.
REQ-015 frame_abort  output  1  one-cycle pulse; partial frame discarded.

Function
REQ-016 States: IDLE, ASSEMBLE, WRITE, CHECK (CHECK exists only with the macro; see REQ-033).
REQ-017 IDLE: in_ready=1; bytes without in_sof are accepted and discarded; an in_sof byte becomes byte 0 of chunk 0 and the block enters ASSEMBLE.
REQ-018 ASSEMBLE: in_ready=1; accepted bytes fill byte slots 0..3 in order per MSB_FIRST; acceptance of byte 3 moves to WRITE.
REQ-019 WRITE lasts exactly one cycle: chunk_write_enable=1, in_ready=0, chunk_data and all addresses stable and valid for that cycle.
REQ-020 Latency: chunk_write_enable asserts on the cycle immediately after byte 3 is accepted.
REQ-021 Address order after each write: chunk_addr increments first; a wrap from 15 to 0 increments row_addr; a wrap of row_addr from 15 to 0 increments panel_addr.
REQ-022 The final write is panel LAST_PANEL, row 15, chunk 15; the frame then completes (REQ-024 or REQ-034).
REQ-023 Address outputs hold their last value between writes; they change only after a WRITE cycle or on sof or abort.
REQ-024 Without the macro, frame_done pulses the cycle after the final write, addresses return to 0, and the state returns to IDLE.
REQ-025 in_sof accepted in ASSEMBLE or CHECK: frame_abort pulses the next cycle; the partial word is discarded; addresses reset to 0; the sof byte is taken as byte 0 of the new frame; the state stays or becomes ASSEMBLE.
REQ-026 in_sof accepted in IDLE does not pulse frame_abort.
REQ-027 frame_done and frame_abort never assert in the same cycle.
REQ-028 in_valid while in_ready=0: the byte is not consumed; the source holds it.

Reset
REQ-029 While reset_n=0, all outputs and state reset immediately: state=IDLE, chunk_data=0, all addresses=0, chunk_write_enable=0, frame_done=0, frame_abort=0, checksum_error=0, in_ready=1.
REQ-030 Reset mid-frame discards all progress and emits no pulse; the next frame requires in_sof.

Configuration
REQ-031 Macro FRAME_CHECKSUM_EN enables frame checksum checking.
REQ-032 With FRAME_CHECKSUM_EN defined, an extra output port is present: checksum_error  output  1  result of the last frame's checksum compare, held until the next frame_done or reset.
REQ-033 With the macro: the final write leads to CHECK with in_ready=1; the next accepted non-sof byte is compared with the sum mod 256 of all 4096 data bytes; frame_done pulses the following cycle; checksum_error updates in the same cycle; the state returns to IDLE.
REQ-034 Without the macro: CHECK and checksum_error are absent, and behaviour follows REQ-024.

Structure
REQ-035 The shared package chunk_writer_pkg holds the state enum and the constants BYTES_PER_CHUNK=4, CHUNKS_PER_ROW=16, ROWS_PER_PANEL=16.
REQ-036 The sub-module chunk_addr_sequencer implements the cascaded chunk/row/panel counters with clear, advance, and last-write flag.

Verification
REQ-037 Reset, then sof with bytes 0x11,0x22,0x33,0x44 -> one strobe, chunk_data=0x44332211, addrs 0/0/0, in_ready=0 during the strobe.
REQ-038 MSB_FIRST=1, same bytes -> chunk_data=0x11223344.
REQ-039 Full 4096-byte frame at in_valid=1 -> 1024 strobes, each every 5 cycles; last strobe has addrs 15/15/3; frame_done follows one cycle after the last strobe.
REQ-040 sof reissued after 6 bytes -> frame_abort pulse, no strobe for the partial word, next strobe at addrs 0/0/0.
REQ-041 FRAME_CHECKSUM_EN, all bytes 0x01, checksum byte 0x00 -> frame_done and checksum_error=0; checksum byte 0x05 -> checksum_error=1.
REQ-042 reset_n low mid-chunk -> outputs reset immediately; 3 bytes without sof afterwards -> no strobe.

Source files
------------

// File: rtl/chunk_writer_pkg.sv
// Shared types and constants for the chunk stream writer.
// FRAME_CHECKSUM_EN adds the CHECK state used for the per-frame checksum compare.
package chunk_writer_pkg;

  localparam int unsigned BYTES_PER_CHUNK = 4;
  localparam int unsigned CHUNKS_PER_ROW  = 16;
  localparam int unsigned ROWS_PER_PANEL  = 16;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned WORD_W          = BYTE_W * BYTES_PER_CHUNK;
  localparam int unsigned SLOT_W          = $clog2(BYTES_PER_CHUNK);
  localparam int unsigned CHUNK_AW        = $clog2(CHUNKS_PER_ROW);
  localparam int unsigned ROW_AW          = $clog2(ROWS_PER_PANEL);
  localparam int unsigned PANEL_AW        = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSEMBLE,
    ST_WRITE
`ifdef FRAME_CHECKSUM_EN
    , ST_CHECK
`endif
  } state_e;

  // Drop one byte into its lane of a chunk word; slot 0 is the first byte received.
  function automatic logic [WORD_W-1:0] place_byte(input logic [WORD_W-1:0] word,
                                                   input logic [BYTE_W-1:0] data,
                                                   input logic [SLOT_W-1:0] slot,
                                                   input logic              msb_first);
    logic [WORD_W-1:0] w;
    logic [SLOT_W-1:0] pos;
    w   = word;
    pos = msb_first ? (SLOT_W'(BYTES_PER_CHUNK - 1) - slot) : slot;
    w[BYTE_W*pos +: BYTE_W] = data;
    return w;
  endfunction

endpackage

// File: rtl/chunk_addr_sequencer.sv
// Cascaded chunk -> row -> panel address counters for the chunk stream writer.
// last_write_c flags the final address of a frame; advancing from it wraps to zero.
module chunk_addr_sequencer
  import chunk_writer_pkg::*;
#(
  parameter int unsigned LAST_PANEL = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                advance,
  output logic [CHUNK_AW-1:0] chunk_addr,
  output logic [ROW_AW-1:0]   row_addr,
  output logic [PANEL_AW-1:0] panel_addr,
  output logic                last_write_c
);

  logic [CHUNK_AW-1:0] chunk_q;
  logic [ROW_AW-1:0]   row_q;
  logic [PANEL_AW-1:0] panel_q;
  logic                chunk_wrap_c;
  logic                row_wrap_c;

  assign chunk_wrap_c = (chunk_q == CHUNK_AW'(CHUNKS_PER_ROW - 1));
  assign row_wrap_c   = (row_q == ROW_AW'(ROWS_PER_PANEL - 1));
  assign last_write_c = chunk_wrap_c && row_wrap_c && (panel_q == PANEL_AW'(LAST_PANEL));

  // Clear wins over advance; advancing past the last write restarts at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chunk_q <= '0;
      row_q   <= '0;
      panel_q <= '0;
    end else if (clear || (advance && last_write_c)) begin
      chunk_q <= '0;
      row_q   <= '0;
      panel_q <= '0;
    end else if (advance) begin
      chunk_q <= chunk_q + CHUNK_AW'(1);
      if (chunk_wrap_c) begin
        row_q <= row_q + ROW_AW'(1);
        if (row_wrap_c) begin
          panel_q <= panel_q + PANEL_AW'(1);
        end
      end
    end
  end

  assign chunk_addr = chunk_q;
  assign row_addr   = row_q;
  assign panel_addr = panel_q;

endmodule

// File: rtl/chunk_stream_writer.sv
// Packs a host byte stream into 32-bit chunk writes addressed by panel/row/chunk.
// Define FRAME_CHECKSUM_EN to add a trailing checksum byte check and checksum_error.
module chunk_stream_writer
  import chunk_writer_pkg::*;
#(
  parameter int unsigned LAST_PANEL = 3,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [BYTE_W-1:0]   in_data,
  input  logic                in_valid,
  input  logic                in_sof,
  output logic                in_ready,
  output logic [WORD_W-1:0]   chunk_data,
  output logic [CHUNK_AW-1:0] chunk_addr,
  output logic [ROW_AW-1:0]   row_addr,
  output logic [PANEL_AW-1:0] panel_addr,
  output logic                chunk_write_enable,
`ifdef FRAME_CHECKSUM_EN
  output logic                checksum_error,
`endif
  output logic                frame_done,
  output logic                frame_abort
);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                we_q, we_d;
  logic                done_q, done_d;
  logic                abort_q, abort_d;
  logic                ready_q, ready_d;
  logic                accept_c;
  logic                seq_clear_c;
  logic                seq_advance_c;
  logic                last_write_c;
`ifdef FRAME_CHECKSUM_EN
  logic [BYTE_W-1:0]   sum_q, sum_d;
  logic                cerr_q, cerr_d;
`endif

  assign accept_c      = in_valid && ready_q;
  assign seq_advance_c = (state_q == ST_WRITE);

  chunk_addr_sequencer #(
    .LAST_PANEL (LAST_PANEL)
  ) u_seq (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (seq_clear_c),
    .advance      (seq_advance_c),
    .chunk_addr   (chunk_addr),
    .row_addr     (row_addr),
    .panel_addr   (panel_addr),
    .last_write_c (last_write_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      slot_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      ready_q <= 1'b1;
`ifdef FRAME_CHECKSUM_EN
      sum_q   <= '0;
      cerr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      slot_q  <= slot_d;
      we_q    <= we_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      ready_q <= ready_d;
`ifdef FRAME_CHECKSUM_EN
      sum_q   <= sum_d;
      cerr_q  <= cerr_d;
`endif
    end
  end

  // Next-state and registered-output logic; an accepted sof always restarts the frame.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    slot_d      = slot_q;
    we_d        = 1'b0;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    seq_clear_c = 1'b0;
`ifdef FRAME_CHECKSUM_EN
    sum_d       = sum_q;
    cerr_d      = cerr_q;
`endif

    if (accept_c && in_sof && (state_q != ST_WRITE)) begin
      abort_d     = (state_q != ST_IDLE);
      seq_clear_c = 1'b1;
      word_d      = place_byte('0, in_data, '0, MSB_FIRST);
      slot_d      = SLOT_W'(1);
      state_d     = ST_ASSEMBLE;
`ifdef FRAME_CHECKSUM_EN
      sum_d       = in_data;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ASSEMBLE: begin
          if (accept_c) begin
            word_d = place_byte(word_q, in_data, slot_q, MSB_FIRST);
            slot_d = slot_q + SLOT_W'(1);
`ifdef FRAME_CHECKSUM_EN
            sum_d  = sum_q + in_data;
`endif
            if (slot_q == SLOT_W'(BYTES_PER_CHUNK - 1)) begin
              we_d    = 1'b1;
              state_d = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (last_write_c) begin
`ifdef FRAME_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            done_d  = 1'b1;
            state_d = ST_IDLE;
`endif
          end else begin
            state_d = ST_ASSEMBLE;
          end
        end
`ifdef FRAME_CHECKSUM_EN
        ST_CHECK: begin
          if (accept_c) begin
            cerr_d  = (in_data != sum_q);
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    ready_d = (state_d != ST_WRITE);
  end

  assign in_ready           = ready_q;
  assign chunk_data         = word_q;
  assign chunk_write_enable = we_q;
  assign frame_done         = done_q;
  assign frame_abort        = abort_q;
`ifdef FRAME_CHECKSUM_EN
  assign checksum_error     = cerr_q;
`endif

endmodule

// File: tb/tb_chunk_stream_writer.sv
// Directed self-checking bench for chunk_stream_writer (LSB-first and MSB-first instances).
module tb_chunk_stream_writer;

  logic        clk;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_sof;
  logic        in_ready;
  logic [31:0] chunk_data;
  logic [3:0]  chunk_addr;
  logic [3:0]  row_addr;
  logic [1:0]  panel_addr;
  logic        chunk_write_enable;
  logic        frame_done;
  logic        frame_abort;
  logic        m_in_ready;
  logic [31:0] m_chunk_data;
  logic [3:0]  m_chunk_addr;
  logic [3:0]  m_row_addr;
  logic [1:0]  m_panel_addr;
  logic        m_we;
  logic        m_done;
  logic        m_abort;
`ifdef FRAME_CHECKSUM_EN
  logic        checksum_error;
  logic        m_checksum_error;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;

  // Monitor records
  int          strobe_cnt = 0;
  int          strobe_cyc = 0;
  logic [31:0] last_data = '0;
  logic [3:0]  last_chunk = '0;
  logic [3:0]  last_row = '0;
  logic [1:0]  last_panel = '0;
  int          ready_bad = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          abort_cnt = 0;
  int          overlap = 0;
  int          gap_err = 0;
  bit          gap_chk = 0;
  int          m_strobe_cnt = 0;
  logic [31:0] m_last_data = '0;

  chunk_stream_writer #(.LAST_PANEL(3), .MSB_FIRST(1'b0)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .in_data            (in_data),
    .in_valid           (in_valid),
    .in_sof             (in_sof),
    .in_ready           (in_ready),
    .chunk_data         (chunk_data),
    .chunk_addr         (chunk_addr),
    .row_addr           (row_addr),
    .panel_addr         (panel_addr),
    .chunk_write_enable (chunk_write_enable),
`ifdef FRAME_CHECKSUM_EN
    .checksum_error     (checksum_error),
`endif
    .frame_done         (frame_done),
    .frame_abort        (frame_abort)
  );

  chunk_stream_writer #(.LAST_PANEL(3), .MSB_FIRST(1'b1)) dut_msb (
    .clk                (clk),
    .reset_n            (reset_n),
    .in_data            (in_data),
    .in_valid           (in_valid),
    .in_sof             (in_sof),
    .in_ready           (m_in_ready),
    .chunk_data         (m_chunk_data),
    .chunk_addr         (m_chunk_addr),
    .row_addr           (m_row_addr),
    .panel_addr         (m_panel_addr),
    .chunk_write_enable (m_we),
`ifdef FRAME_CHECKSUM_EN
    .checksum_error     (m_checksum_error),
`endif
    .frame_done         (m_done),
    .frame_abort        (m_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (chunk_write_enable) begin
      if (gap_chk && (cyc - strobe_cyc != 5)) gap_err++;
      strobe_cnt++;
      strobe_cyc = cyc;
      last_data  = chunk_data;
      last_chunk = chunk_addr;
      last_row   = row_addr;
      last_panel = panel_addr;
      if (in_ready) ready_bad++;
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (frame_abort) abort_cnt++;
    if (frame_done && frame_abort) overlap++;
    if (m_we) begin
      m_strobe_cnt++;
      m_last_data = m_chunk_data;
    end
  end

  task automatic put(input logic [7:0] b, input logic sof);
    bit ok;
    in_data  = b;
    in_sof   = sof;
    in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        acc_cyc = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL put_timeout: byte %h not accepted within 20 cycles", b);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (chunk_data !== 32'h0) begin errors++; $display("FAIL reset_chunk_data: got %h expected 0", chunk_data); end
    checks++; if ({chunk_addr, row_addr, panel_addr} !== 10'h0) begin errors++; $display("FAIL reset_addrs: got %h expected 0", {chunk_addr, row_addr, panel_addr}); end
    checks++; if (chunk_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", chunk_write_enable); end
    checks++; if ({frame_done, frame_abort} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {frame_done, frame_abort}); end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_chunk();
    int s0, a0, ms0;
    do_reset();
    s0 = strobe_cnt; a0 = abort_cnt; ms0 = m_strobe_cnt;
    put(8'h11, 1'b1);
    put(8'h22, 1'b0);
    put(8'h33, 1'b0);
    put(8'h44, 1'b0);
    idle(3);
    checks++; if (strobe_cnt - s0 !== 1) begin errors++; $display("FAIL single_strobes: got %0d expected 1", strobe_cnt - s0); end
    checks++; if (last_data !== 32'h44332211) begin errors++; $display("FAIL single_data: got %h expected 44332211", last_data); end
    checks++; if ({last_chunk, last_row, last_panel} !== 10'h0) begin errors++; $display("FAIL single_addrs: got %h expected 0", {last_chunk, last_row, last_panel}); end
    checks++; if (ready_bad !== 0) begin errors++; $display("FAIL single_ready_in_write: got %0d expected 0", ready_bad); end
    checks++; if (strobe_cyc !== acc_cyc) begin errors++; $display("FAIL single_latency: strobe cycle %0d expected %0d", strobe_cyc, acc_cyc); end
    checks++; if (abort_cnt - a0 !== 0) begin errors++; $display("FAIL idle_sof_abort: got %0d expected 0", abort_cnt - a0); end
    checks++; if (m_strobe_cnt - ms0 !== 1 || m_last_data !== 32'h11223344) begin errors++; $display("FAIL msb_first_data: got %h expected 11223344", m_last_data); end
  endtask

  task automatic test_abort();
    int s0, a0, d0;
    do_reset();
    s0 = strobe_cnt; a0 = abort_cnt; d0 = done_cnt;
    put(8'hA0, 1'b1);
    for (int i = 1; i < 6; i++) put(8'hA0 + 8'(i), 1'b0);
    put(8'hB0, 1'b1);
    put(8'hB1, 1'b0);
    put(8'hB2, 1'b0);
    put(8'hB3, 1'b0);
    idle(3);
    checks++; if (abort_cnt - a0 !== 1) begin errors++; $display("FAIL abort_pulse: got %0d expected 1", abort_cnt - a0); end
    checks++; if (strobe_cnt - s0 !== 2) begin errors++; $display("FAIL abort_strobes: got %0d expected 2", strobe_cnt - s0); end
    checks++; if (last_data !== 32'hB3B2B1B0) begin errors++; $display("FAIL abort_new_data: got %h expected b3b2b1b0", last_data); end
    checks++; if ({last_chunk, last_row, last_panel} !== 10'h0) begin errors++; $display("FAIL abort_addrs: got %h expected 0", {last_chunk, last_row, last_panel}); end
    checks++; if (done_cnt - d0 !== 0 || overlap !== 0) begin errors++; $display("FAIL abort_done: got done %0d overlap %0d expected 0 0", done_cnt - d0, overlap); end
  endtask

  task automatic test_full_frame();
    int s0, a0, d0;
    do_reset();
    s0 = strobe_cnt; a0 = abort_cnt; d0 = done_cnt;
    for (int i = 0; i < 4096; i++) begin
      if (i == 5) gap_chk = 1'b1;
      put(8'(i), i == 0);
    end
    idle(3);
    gap_chk = 1'b0;
    checks++; if (strobe_cnt - s0 !== 1024) begin errors++; $display("FAIL frame_strobes: got %0d expected 1024", strobe_cnt - s0); end
    checks++; if (gap_err !== 0) begin errors++; $display("FAIL frame_spacing: got %0d bad gaps expected 0", gap_err); end
    checks++; if ({last_chunk, last_row, last_panel} !== {4'd15, 4'd15, 2'd3}) begin errors++; $display("FAIL frame_last_addrs: got %0d/%0d/%0d expected 15/15/3", last_chunk, last_row, last_panel); end
    checks++; if (last_data !== 32'hFFFEFDFC) begin errors++; $display("FAIL frame_last_data: got %h expected fffefdfc", last_data); end
    checks++; if (abort_cnt - a0 !== 0) begin errors++; $display("FAIL frame_abort: got %0d expected 0", abort_cnt - a0); end
`ifndef FRAME_CHECKSUM_EN
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (done_cyc !== strobe_cyc + 1) begin errors++; $display("FAIL frame_done_timing: got cycle %0d expected %0d", done_cyc, strobe_cyc + 1); end
    checks++; if ({chunk_addr, row_addr, panel_addr} !== 10'h0) begin errors++; $display("FAIL frame_addr_return: got %h expected 0", {chunk_addr, row_addr, panel_addr}); end
`endif
  endtask

  task automatic test_reset_mid_chunk();
    int s0;
    do_reset();
    put(8'h5A, 1'b1);
    for (int i = 1; i < 6; i++) put(8'h5A, 1'b0);
    reset_n = 1'b0;
    #2;
    checks++; if (chunk_data !== 32'h0) begin errors++; $display("FAIL midreset_data: got %h expected 0", chunk_data); end
    checks++; if (chunk_addr !== 4'd0) begin errors++; $display("FAIL midreset_chunk_addr: got %0d expected 0", chunk_addr); end
    checks++; if (in_ready !== 1'b1 || frame_abort !== 1'b0) begin errors++; $display("FAIL midreset_ready_abort: got %b%b expected 10", in_ready, frame_abort); end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    s0 = strobe_cnt;
    for (int i = 0; i < 4; i++) put(8'h77, 1'b0);
    idle(3);
    checks++; if (strobe_cnt - s0 !== 0) begin errors++; $display("FAIL midreset_no_sof_strobe: got %0d expected 0", strobe_cnt - s0); end
  endtask

`ifdef FRAME_CHECKSUM_EN
  task automatic test_checksum();
    int d0;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      d0 = done_cnt;
      for (int i = 0; i < 4096; i++) put(8'h01, i == 0);
      put((pass == 0) ? 8'h00 : 8'h05, 1'b0);
      idle(2);
      checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL checksum_done_%0d: got %0d expected 1", pass, done_cnt - d0); end
      checks++; if (checksum_error !== (pass == 1)) begin errors++; $display("FAIL checksum_error_%0d: got %b expected %b", pass, checksum_error, pass == 1); end
    end
  endtask
`endif

  initial begin
    reset_n  = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    test_reset();
    test_single_chunk();
    test_abort();
    test_full_frame();
    test_reset_mid_chunk();
`ifdef FRAME_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
